// File: rtl/run_ctrl.sv
// Run controller: staggered per-channel core resets, halt/timeout detection on the
// core's retired-PC stream, cycle and instruction counters, restart from DONE.
module run_ctrl #(
  parameter int unsigned NUM_RST     = 2,
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned RST_STAGGER = 2,
  parameter int unsigned HALT_REPEAT = 8,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [PC_W-1:0]    i_pc_debug,
  input  logic               i_insn_vld,
  output logic [NUM_RST-1:0] o_rst_n,
  output logic               o_running,
  output logic               o_done,
  output logic               o_halted,
  output logic               o_timeout,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic [CNT_W-1:0]   o_insn_cnt
);

  localparam int unsigned C_LAST = RST_HOLD + (NUM_RST - 1) * RST_STAGGER;
  localparam int unsigned SEQ_W  = $clog2(C_LAST + 1);
  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {
    ST_SEQ  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic [NUM_RST-1:0] rst_n_q, rst_n_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   insn_cnt_q, insn_cnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [PC_W-1:0]    last_pc_q, last_pc_d;
  logic               pc_vld_q, pc_vld_d;

  logic [CNT_W-1:0]   cyc_inc_c;
  logic [CNT_W-1:0]   insn_inc_c;
  logic [REP_W-1:0]   rep_nxt_c;
  logic               halt_hit_c;
  logic               tmo_hit_c;

  // Saturating increments and the halt/timeout conditions for this edge.
  always_comb begin
    cyc_inc_c  = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    insn_inc_c = (insn_cnt_q == '1) ? insn_cnt_q : insn_cnt_q + CNT_W'(1);
    rep_nxt_c  = (pc_vld_q && (i_pc_debug == last_pc_q)) ? rep_q + REP_W'(1) : REP_W'(1);
    halt_hit_c = i_insn_vld && (rep_nxt_c == REP_W'(HALT_REPEAT));
    tmo_hit_c  = (cyc_inc_c == CNT_W'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_SEQ;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEQ:  if (seq_cnt_q == SEQ_W'(C_LAST)) state_d = ST_RUN;
      ST_RUN:  if (halt_hit_c || tmo_hit_c) state_d = ST_DONE;
      ST_DONE: if (i_start) state_d = ST_SEQ;
      default: state_d = ST_SEQ;
    endcase
  end

  // Output / datapath next values; everything holds unless the state says otherwise.
  always_comb begin
    seq_cnt_d   = seq_cnt_q;
    rst_n_d     = rst_n_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    cycle_cnt_d = cycle_cnt_q;
    insn_cnt_d  = insn_cnt_q;
    rep_d       = rep_q;
    last_pc_d   = last_pc_q;
    pc_vld_d    = pc_vld_q;
    case (state_q)
      ST_SEQ: begin
        if (seq_cnt_q != SEQ_W'(C_LAST)) seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        for (int unsigned k = 0; k < NUM_RST; k++) begin
          if (32'(seq_cnt_d) >= RST_HOLD + k * RST_STAGGER) rst_n_d[k] = 1'b1;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cyc_inc_c;
        if (i_insn_vld) begin
          insn_cnt_d = insn_inc_c;
          rep_d      = rep_nxt_c;
          last_pc_d  = i_pc_debug;
          pc_vld_d   = 1'b1;
        end
        halted_d  = halt_hit_c;
        timeout_d = tmo_hit_c && !halt_hit_c;
      end
      ST_DONE: begin
        // Restart: cores go back into reset and the run starts from a clean slate.
        if (i_start) begin
          seq_cnt_d   = '0;
          rst_n_d     = '0;
          halted_d    = 1'b0;
          timeout_d   = 1'b0;
          cycle_cnt_d = '0;
          insn_cnt_d  = '0;
          rep_d       = '0;
          last_pc_d   = '0;
          pc_vld_d    = 1'b0;
        end
      end
      default: ;
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      seq_cnt_q   <= '0;
      rst_n_q     <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      cycle_cnt_q <= '0;
      insn_cnt_q  <= '0;
      rep_q       <= '0;
      last_pc_q   <= '0;
      pc_vld_q    <= 1'b0;
    end else begin
      seq_cnt_q   <= seq_cnt_d;
      rst_n_q     <= rst_n_d;
      running_q   <= running_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      cycle_cnt_q <= cycle_cnt_d;
      insn_cnt_q  <= insn_cnt_d;
      rep_q       <= rep_d;
      last_pc_q   <= last_pc_d;
      pc_vld_q    <= pc_vld_d;
    end
  end

  assign o_rst_n     = rst_n_q;
  assign o_running   = running_q;
  assign o_done      = done_q;
  assign o_halted    = halted_q;
  assign o_timeout   = timeout_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_insn_cnt  = insn_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: reset stagger, halt detection, gap handling,
// timeout, halt/timeout tie, restart and mid-run reset.
module tb_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        vld;
  logic [1:0]  o_rst_n;
  logic        o_running;
  logic        o_done;
  logic        o_halted;
  logic        o_timeout;
  logic [31:0] o_cycle_cnt;
  logic [31:0] o_insn_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  run_ctrl #(
    .NUM_RST    (2),
    .RST_HOLD   (4),
    .RST_STAGGER(2),
    .HALT_REPEAT(8),
    .TIMEOUT    (20),
    .PC_W       (32),
    .CNT_W      (32)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_pc_debug (pc),
    .i_insn_vld (vld),
    .o_rst_n    (o_rst_n),
    .o_running  (o_running),
    .o_done     (o_done),
    .o_halted   (o_halted),
    .o_timeout  (o_timeout),
    .o_cycle_cnt(o_cycle_cnt),
    .o_insn_cnt (o_insn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given core inputs; outputs settle 1ns after the edge.
  task automatic step(input logic [31:0] p, input logic v);
    pc  = p;
    vld = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_n"},   64'(o_rst_n), 64'd0);
    chk({tag, "_running"}, 64'(o_running), 64'd0);
    chk({tag, "_done"},    64'(o_done), 64'd0);
    chk({tag, "_halted"},  64'(o_halted), 64'd0);
    chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    chk({tag, "_cycle"},   64'(o_cycle_cnt), 64'd0);
    chk({tag, "_insn"},    64'(o_insn_cnt), 64'd0);
  endtask

  task automatic restart_and_run(input string tag);
    int n;
    start = 1'b1;
    step(32'h0, 1'b0);
    start = 1'b0;
    chk_reset_vals(tag);
    n = 0;
    while (!o_running && n < 12) begin
      step(32'h0, 1'b0);
      n++;
    end
    chk({tag, "_run_wait"}, 64'(o_running), 64'd1);
  endtask

  initial begin
    logic [31:0] pcs2 [11];
    logic [31:0] pcs3 [10];
    logic        vld3 [10];

    rst_n = 1'b0;
    start = 1'b0;
    pc    = '0;
    vld   = 1'b0;

    // 1: reset, then staggered release (bit0 at c=4, bit1 at c=6, RUN after c=6)
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(32'h0, 1'b0);
      chk($sformatf("seq_rst_c%0d", c), 64'(o_rst_n),
          64'({(c >= 6) ? 1'b1 : 1'b0, (c >= 4) ? 1'b1 : 1'b0}));
      chk($sformatf("seq_run_c%0d", c), 64'(o_running), (c >= 7) ? 64'd1 : 64'd0);
    end

    // 2: 0,4,8 then 0xC x8 -> halt with 11 instructions
    pcs2 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};
    for (int i = 0; i < 11; i++) begin
      step(pcs2[i], 1'b1);
      if (i == 9) chk("t2_not_yet", 64'(o_done), 64'd0);
    end
    chk("t2_halted",  64'(o_halted), 64'd1);
    chk("t2_done",    64'(o_done), 64'd1);
    chk("t2_running", 64'(o_running), 64'd0);
    chk("t2_timeout", 64'(o_timeout), 64'd0);
    chk("t2_insn",    64'(o_insn_cnt), 64'd11);
    chk("t2_cycle",   64'(o_cycle_cnt), 64'd11);
    // DONE freezes counters and keeps cores out of reset
    step(32'h20, 1'b1);
    step(32'h20, 1'b1);
    chk("done_frz_insn",  64'(o_insn_cnt), 64'd11);
    chk("done_frz_cycle", 64'(o_cycle_cnt), 64'd11);
    chk("done_frz_rst",   64'(o_rst_n), 64'd3);
    chk("done_frz_halt",  64'(o_halted), 64'd1);

    // 3: 0xC x7 with gaps, 0x10, then 0xC x8
    restart_and_run("r3");
    pcs3 = '{32'hC, 32'hC, 32'h0, 32'hC, 32'hC, 32'hC, 32'h0, 32'hC, 32'hC, 32'h10};
    vld3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) step(pcs3[i], vld3[i]);
    chk("t3_after_10", 64'(o_done), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step(32'hC, 1'b1);
      if (i == 6) chk("t3_7th_c", 64'(o_done), 64'd0);
    end
    chk("t3_halted", 64'(o_halted), 64'd1);
    chk("t3_insn",   64'(o_insn_cnt), 64'd16);
    chk("t3_cycle",  64'(o_cycle_cnt), 64'd18);

    // 4: idle core -> timeout at cycle 20
    restart_and_run("r4");
    for (int i = 0; i < 19; i++) step(32'h0, 1'b0);
    chk("t4_c19_done", 64'(o_done), 64'd0);
    step(32'h0, 1'b0);
    chk("t4_timeout", 64'(o_timeout), 64'd1);
    chk("t4_halted",  64'(o_halted), 64'd0);
    chk("t4_done",    64'(o_done), 64'd1);
    chk("t4_cycle",   64'(o_cycle_cnt), 64'd20);
    chk("t4_insn",    64'(o_insn_cnt), 64'd0);

    // 5: 8th repeat lands on RUN edge 20 -> halt wins
    restart_and_run("r5");
    for (int i = 0; i < 12; i++) step(32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(32'hC, 1'b1);
    chk("t5_halted",  64'(o_halted), 64'd1);
    chk("t5_timeout", 64'(o_timeout), 64'd0);
    chk("t5_cycle",   64'(o_cycle_cnt), 64'd20);
    chk("t5_insn",    64'(o_insn_cnt), 64'd8);

    // 6: i_start ignored in RUN; reset mid-run aborts in one edge
    restart_and_run("r6");
    start = 1'b1;
    step(32'h40, 1'b1);
    start = 1'b0;
    step(32'h44, 1'b1);
    step(32'h48, 1'b1);
    chk("t6_still_run", 64'(o_running), 64'd1);
    chk("t6_insn",      64'(o_insn_cnt), 64'd3);
    chk("t6_cycle",     64'(o_cycle_cnt), 64'd3);
    rst_n = 1'b0;
    step(32'h4C, 1'b1);
    chk_reset_vals("midrun_rst");
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
